tcp_vlg_tx_buf: RTL and testbench

//  TCP transmit-side user buffer: the TCP end of the user tx data/cts handshake. Accepts user bytes
//  (dat/val) into a circular RAM and drives cts. Cuts the byte stream into segments of at most MTU

---
 rtl/tcp_vlg_tx_buf_if.sv | 36 +++
 rtl/tcp_vlg_tx_buf.sv | 150 +++++++++++++++
 tb/tb_tcp_vlg_tx_buf.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tcp_vlg_tx_buf_if.sv
`default_nettype none
// ============================================================================
//  Module   : tcp_vlg_tx_buf_if
//  Brief    : User byte stream, segment offer, remote-ACK and read-port bundle
//             for the TCP transmit buffer.
//  Revision : 1.0  initial release
// ============================================================================
interface tcp_vlg_tx_buf_if #(
  parameter int D = 12
) ();
  logic [7:0]   in_dat;
  logic         in_val;
  logic         in_cts;
  logic         flush;
  logic         pkt_val;
  logic [D:0]   pkt_ptr;
  logic [15:0]  pkt_len;
  logic         pkt_ack;
  logic         ack_val;
  logic [D:0]   ack_ptr;
  logic [D-1:0] rd_addr;
  logic [7:0]   rd_dat;
  logic         ovf;
  logic         ack_err;

  modport master (
    output in_dat, in_val, flush, pkt_ack, ack_val, ack_ptr, rd_addr,
    input  in_cts, pkt_val, pkt_ptr, pkt_len, rd_dat, ovf, ack_err
  );

  modport slave (
    input  in_dat, in_val, flush, pkt_ack, ack_val, ack_ptr, rd_addr,
    output in_cts, pkt_val, pkt_ptr, pkt_len, rd_dat, ovf, ack_err
  );
endinterface
`default_nettype wire

// File: rtl/tcp_vlg_tx_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tcp_vlg_tx_buf
//  Brief    : TCP transmit user buffer. Circular byte RAM, MTU segmenter with
//             idle-timeout / flush, RAM released only on remote ACK.
//  Revision : 1.0  initial release
// ============================================================================
module tcp_vlg_tx_buf #(
  parameter int D        = 12,
  parameter int MTU      = 1460,
  parameter int TIMEOUT  = 1250,
  parameter int HEADROOM = 2
) (
  input  logic                clk,
  input  logic                rst,
  tcp_vlg_tx_buf_if.slave     bus
);

  localparam int            PW       = D + 1;
  localparam int            IW       = $clog2(TIMEOUT + 1);
  localparam logic [D:0]    c_depth  = {1'b1, {D{1'b0}}};
  localparam logic [D:0]    c_mtu    = PW'(MTU);
  localparam logic [IW-1:0] c_tmax   = IW'(TIMEOUT);
  localparam logic [IW-1:0] c_tlast  = IW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_PEND  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     mem [0:(1<<D)-1];
  logic [D:0]     wr_ptr_q, wr_ptr_d;
  logic [D:0]     seg_ptr_q, seg_ptr_d;
  logic [D:0]     free_ptr_q, free_ptr_d;
  logic [D:0]     pkt_ptr_q, pkt_ptr_d;
  logic [15:0]    pkt_len_q, pkt_len_d;
  logic           pkt_val_q, pkt_val_d;
  logic           in_cts_q, in_cts_d;
  logic           ovf_q, ovf_d;
  logic           ack_err_q, ack_err_d;
  logic [7:0]     rd_dat_q, rd_dat_d;
  logic [IW-1:0]  idle_q, idle_d;

  logic [D:0]     w_used, w_free, w_acc, w_used_nx, w_free_nx, w_seg_len;
  logic           w_wr_en, w_ack_ok;

  // Pointer bookkeeping, flow control and sticky error flags
  always_comb begin
    w_used     = wr_ptr_q - free_ptr_q;
    w_free     = c_depth - w_used;
    w_acc      = wr_ptr_q - seg_ptr_q;
    w_wr_en    = bus.in_val && (w_free != '0);
    w_ack_ok   = bus.ack_val && ((bus.ack_ptr - free_ptr_q) <= w_used);
    wr_ptr_d   = w_wr_en  ? wr_ptr_q + PW'(1) : wr_ptr_q;
    free_ptr_d = w_ack_ok ? bus.ack_ptr       : free_ptr_q;
    w_used_nx  = wr_ptr_d - free_ptr_d;
    w_free_nx  = c_depth - w_used_nx;
    in_cts_d   = 32'(w_free_nx) > 32'(HEADROOM);
    ovf_d      = ovf_q | (bus.in_val && (w_free == '0));
    ack_err_d  = ack_err_q | (bus.ack_val && !w_ack_ok);
    rd_dat_d   = mem[bus.rd_addr];
    if (w_wr_en) begin
      idle_d = '0;
    end else if (idle_q == c_tmax) begin
      idle_d = idle_q;
    end else begin
      idle_d = idle_q + IW'(1);
    end
    w_seg_len  = (32'(w_acc) >= 32'(MTU)) ? c_mtu : w_acc;
  end

  // Segmenter FSM
  always_comb begin
    state_d   = state_q;
    seg_ptr_d = seg_ptr_q;
    pkt_ptr_d = pkt_ptr_q;
    pkt_len_d = pkt_len_q;
    pkt_val_d = pkt_val_q;
    case (state_q)
      S_IDLE: begin
        if (w_wr_en) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        // ">=" rather than "==" so a counter that saturated during PEND still flushes
        if ((w_acc != '0) &&
            ((32'(w_acc) >= 32'(MTU)) || (idle_q >= c_tlast) || bus.flush)) begin
          pkt_ptr_d = seg_ptr_q;
          pkt_len_d = 16'(w_seg_len);
          pkt_val_d = 1'b1;
          seg_ptr_d = seg_ptr_q + w_seg_len;
          state_d   = S_PEND;
        end
      end
      S_PEND: begin
        if (bus.pkt_ack) begin
          pkt_val_d = 1'b0;
          state_d   = ((w_acc != '0) || w_wr_en) ? S_ACCUM : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Storage has no reset; read returns the pre-write byte on a collision
  always_ff @(posedge clk) begin
    if (w_wr_en) mem[wr_ptr_q[D-1:0]] <= bus.in_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      seg_ptr_q  <= '0;
      free_ptr_q <= '0;
      pkt_ptr_q  <= '0;
      pkt_len_q  <= '0;
      pkt_val_q  <= 1'b0;
      in_cts_q   <= 1'b0;
      ovf_q      <= 1'b0;
      ack_err_q  <= 1'b0;
      rd_dat_q   <= '0;
      idle_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      seg_ptr_q  <= seg_ptr_d;
      free_ptr_q <= free_ptr_d;
      pkt_ptr_q  <= pkt_ptr_d;
      pkt_len_q  <= pkt_len_d;
      pkt_val_q  <= pkt_val_d;
      in_cts_q   <= in_cts_d;
      ovf_q      <= ovf_d;
      ack_err_q  <= ack_err_d;
      rd_dat_q   <= rd_dat_d;
      idle_q     <= idle_d;
    end
  end

  assign bus.in_cts  = in_cts_q;
  assign bus.pkt_val = pkt_val_q;
  assign bus.pkt_ptr = pkt_ptr_q;
  assign bus.pkt_len = pkt_len_q;
  assign bus.rd_dat  = rd_dat_q;
  assign bus.ovf     = ovf_q;
  assign bus.ack_err = ack_err_q;

endmodule
`default_nettype wire

// File: tb/tb_tcp_vlg_tx_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tcp_vlg_tx_buf
//  Brief    : Directed bench: a D=12 instance for segmenting/wrap/reset and a
//             D=6 instance for flow control, overflow and ACK handling.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tcp_vlg_tx_buf;

  localparam int TOTAL = 3 * 4096;
  localparam int BASE  = 1475;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  tcp_vlg_tx_buf_if #(.D(12)) a_if ();
  tcp_vlg_tx_buf_if #(.D(6))  b_if ();

  tcp_vlg_tx_buf #(.D(12), .MTU(1460), .TIMEOUT(1250), .HEADROOM(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  tcp_vlg_tx_buf #(.D(6), .MTU(16), .TIMEOUT(20), .HEADROOM(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sdat(input int n);
    return 8'(n * 7 + 1);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int wr_n;
    int seg_n;
    logic [12:0] exp_ptr;

    a_if.in_dat = '0; a_if.in_val = 0; a_if.flush = 0; a_if.pkt_ack = 0;
    a_if.ack_val = 0; a_if.ack_ptr = '0; a_if.rd_addr = '0;
    b_if.in_dat = '0; b_if.in_val = 0; b_if.flush = 0; b_if.pkt_ack = 0;
    b_if.ack_val = 0; b_if.ack_ptr = '0; b_if.rd_addr = '0;

    // Reset values
    repeat (3) tick();
    chk("rst_cts",     a_if.in_cts,  0);
    chk("rst_pkt_val", a_if.pkt_val, 0);
    chk("rst_pkt_ptr", a_if.pkt_ptr, 0);
    chk("rst_pkt_len", a_if.pkt_len, 0);
    chk("rst_rd_dat",  a_if.rd_dat,  0);
    chk("rst_ovf",     a_if.ovf,     0);
    chk("rst_ack_err", a_if.ack_err, 0);
    rst = 1'b0;
    #1;
    chk("cts_first_cycle", a_if.in_cts, 0);
    tick();
    chk("cts_up_a", a_if.in_cts, 1);
    chk("cts_up_b", b_if.in_cts, 1);

    // Full MTU segment
    for (int i = 0; i < 1460; i++) begin
      a_if.in_val = 1; a_if.in_dat = 8'(i);
      tick();
    end
    a_if.in_val = 0;
    chk("mtu_not_yet", a_if.pkt_val, 0);
    a_if.rd_addr = 12'd100;
    tick();
    chk("mtu_val", a_if.pkt_val, 1);
    chk("mtu_ptr", a_if.pkt_ptr, 0);
    chk("mtu_len", a_if.pkt_len, 1460);
    chk("rd_100",  a_if.rd_dat,  8'd100);
    tick();
    chk("mtu_hold_val", a_if.pkt_val, 1);
    chk("mtu_hold_len", a_if.pkt_len, 1460);
    a_if.pkt_ack = 1;
    tick();
    a_if.pkt_ack = 0;
    chk("mtu_acked", a_if.pkt_val, 0);
    a_if.ack_val = 1; a_if.ack_ptr = 13'd1460;
    tick();
    a_if.ack_val = 0;
    chk("ack_ok_err", a_if.ack_err, 0);

    // Idle-timeout flush of a 10-byte partial
    for (int i = 0; i < 10; i++) begin
      a_if.in_val = 1; a_if.in_dat = 8'(8'hA0 + i);
      tick();
    end
    a_if.in_val = 0;
    n = 0;
    for (int k = 1; k <= 1400; k++) begin
      tick();
      if (a_if.pkt_val) begin
        n = k;
        break;
      end
    end
    chk("timeout_lat", n, 1250);
    chk("timeout_ptr", a_if.pkt_ptr, 1460);
    chk("timeout_len", a_if.pkt_len, 10);
    a_if.pkt_ack = 1; a_if.ack_val = 1; a_if.ack_ptr = 13'd1470;
    tick();
    a_if.pkt_ack = 0; a_if.ack_val = 0;

    // Explicit flush of a 5-byte partial
    for (int i = 0; i < 5; i++) begin
      a_if.in_val = 1; a_if.in_dat = 8'(8'hB0 + i);
      tick();
    end
    a_if.in_val = 0;
    chk("flush_not_yet", a_if.pkt_val, 0);
    a_if.flush = 1;
    tick();
    a_if.flush = 0;
    chk("flush_val", a_if.pkt_val, 1);
    chk("flush_ptr", a_if.pkt_ptr, 1470);
    chk("flush_len", a_if.pkt_len, 5);
    a_if.pkt_ack = 1; a_if.ack_val = 1; a_if.ack_ptr = 13'd1475;
    tick();
    a_if.pkt_ack = 0; a_if.ack_val = 0;

    // Flow control on the 64-byte instance, no engine acks
    n = 0;
    for (int k = 0; k < 100; k++) begin
      b_if.in_val = 1; b_if.in_dat = 8'(n) ^ 8'h3C;
      tick();
      n++;
      if (!b_if.in_cts) break;
    end
    chk("cts_fall_used", n, 62);
    for (int k = 0; k < 2; k++) begin
      b_if.in_dat = 8'(n) ^ 8'h3C;
      tick();
      n++;
    end
    b_if.in_val = 0;
    b_if.rd_addr = 6'd63;
    tick();
    chk("grace_ovf",  b_if.ovf,    0);
    chk("grace_cts",  b_if.in_cts, 0);
    chk("grace_byte", b_if.rd_dat, 8'd63 ^ 8'h3C);
    chk("b_seg_val",  b_if.pkt_val, 1);
    chk("b_seg_ptr",  b_if.pkt_ptr, 0);
    chk("b_seg_len",  b_if.pkt_len, 16);
    b_if.in_val = 1; b_if.in_dat = 8'hFF;
    tick();
    b_if.in_val = 0;
    b_if.rd_addr = 6'd0;
    chk("ovf_set", b_if.ovf, 1);
    tick();
    chk("ovf_no_overwrite", b_if.rd_dat, 8'h3C);

    // Remote ACK reopens space; write and ack in the same cycle
    b_if.ack_val = 1; b_if.ack_ptr = 7'd32;
    tick();
    chk("ack_cts_up", b_if.in_cts, 1);
    b_if.ack_ptr = 7'd40; b_if.in_val = 1; b_if.in_dat = 8'h77;
    tick();
    b_if.ack_val = 0; b_if.in_val = 0;
    b_if.rd_addr = 6'd0;
    tick();
    chk("ack_wr_same_cyc", b_if.rd_dat, 8'h77);
    chk("ack_err_clean",   b_if.ack_err, 0);
    b_if.ack_val = 1; b_if.ack_ptr = 7'd100;
    tick();
    b_if.ack_val = 0;
    chk("ack_err_beyond", b_if.ack_err, 1);

    // Stream three buffers' worth through the 4 KiB instance with prompt acks
    wr_n = 0;
    seg_n = 0;
    for (int cyc = 0; cyc < 40000 && seg_n < TOTAL; cyc++) begin
      if (a_if.pkt_val) begin
        a_if.in_val = 0; a_if.flush = 0;
        exp_ptr = 13'(BASE + seg_n);
        chk("wrap_seg_ptr", a_if.pkt_ptr, exp_ptr);
        chk("wrap_len_ok", (a_if.pkt_len >= 16'd1 && a_if.pkt_len <= 16'd1460), 1);
        a_if.rd_addr = a_if.pkt_ptr[11:0];
        tick();
        chk("wrap_first", a_if.rd_dat, sdat(seg_n));
        a_if.rd_addr = 12'(a_if.pkt_ptr + 13'(a_if.pkt_len) - 13'd1);
        tick();
        chk("wrap_last", a_if.rd_dat, sdat(seg_n + int'(a_if.pkt_len) - 1));
        a_if.pkt_ack = 1; a_if.ack_val = 1;
        a_if.ack_ptr = a_if.pkt_ptr + 13'(a_if.pkt_len);
        seg_n += int'(a_if.pkt_len);
        tick();
        a_if.pkt_ack = 0; a_if.ack_val = 0;
      end else begin
        a_if.in_val = (wr_n < TOTAL) && a_if.in_cts;
        a_if.in_dat = sdat(wr_n);
        a_if.flush  = (wr_n == TOTAL);
        tick();
        if (a_if.in_val) wr_n++;
      end
    end
    a_if.in_val = 0; a_if.flush = 0;
    chk("wrap_covered", seg_n, TOTAL);
    chk("wrap_ack_err", a_if.ack_err, 0);

    // Reset while a segment is pending
    for (int i = 0; i < 5; i++) begin
      a_if.in_val = 1; a_if.in_dat = 8'(i);
      tick();
    end
    a_if.in_val = 0; a_if.flush = 1;
    tick();
    a_if.flush = 0;
    chk("pend_val", a_if.pkt_val, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_val", a_if.pkt_val, 0);
    chk("rst_mid_cts", a_if.in_cts,  0);
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      a_if.in_val = 1; a_if.in_dat = 8'(i);
      tick();
    end
    a_if.in_val = 0; a_if.flush = 1;
    tick();
    a_if.flush = 0;
    chk("post_rst_val", a_if.pkt_val, 1);
    chk("post_rst_ptr", a_if.pkt_ptr, 0);
    chk("post_rst_len", a_if.pkt_len, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
